// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midi_pkg
// Description : Shared MIDI transmit definitions: default bit period,
//               serialiser state encoding and message-length helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    // 100 MHz / 31250 baud
    localparam int c_CYCLES_PER_BIT_DEFAULT = 3200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } midi_tx_state_t;

    // Number of data bytes that follow a given status byte.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status_byte);
        logic [1:0] len;
        len = 2'd0;
        case (status_byte[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
            4'hC, 4'hD:                   len = 2'd1;
            4'hF: begin
                case (status_byte[3:0])
                    4'h1, 4'h3: len = 2'd1;
                    4'h2:       len = 2'd2;
                    default:    len = 2'd0;
                endcase
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

    // Channel-voice messages (8x..Ex) are the only ones eligible for
    // running-status compression.
    function automatic logic is_channel_voice(input logic [7:0] status_byte);
        return status_byte[7] && (status_byte[6:4] != 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_transmit_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serialiser, LSB first. A byte offered on the last
//               cycle of a stop bit starts immediately, giving back-to-back
//               frames.
// Ports       : clk, rst (async, active high)
//               byte_valid / byte_data[7:0] : byte offered
//               byte_ready : byte accepted this cycle if byte_valid
//               byte_done  : last cycle of the stop bit
//               dout       : registered serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import midi_pkg::*;
#(
    parameter int CYCLES_PER_BIT = c_CYCLES_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       dout
);

    localparam int c_CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CYCLES_PER_BIT - 1);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_START = START;
    localparam logic [1:0] c_ST_DATA  = DATA;
    localparam logic [1:0] c_ST_STOP  = STOP;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_dout;
    logic               w_bit_end;

    assign w_bit_end  = (r_cnt == c_CNT_LAST);
    assign byte_done  = (r_state == c_ST_STOP) && w_bit_end;
    assign byte_ready = (r_state == c_ST_IDLE) || byte_done;
    assign dout       = r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_dout  <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (byte_valid) begin
                        r_shift <= byte_data;
                        r_cnt   <= '0;
                        r_dout  <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_dout  <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_dout  <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_dout  <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (byte_valid) begin
                            // Next byte's start bit follows with no gap
                            r_shift <= byte_data;
                            r_dout  <= 1'b0;
                            r_state <= c_ST_START;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_dout  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_transmit.sv
`default_nettype none
// ============================================================================
// Module      : midi_transmit
// Description : MIDI OUT message sequencer. Accepts one message per
//               din_valid/ready handshake, applies optional running-status
//               compression and serialises 1..3 bytes at 31250 baud 8N1.
// Ports       : clk, rst (async, active high)
//               din_valid, status[6:0], data1[6:0], data2[6:0] : message in
//               ready : idle, message can be accepted
//               dout  : serial MIDI line (registered, idle high)
//               done  : pulse on the final stop-bit cycle of a message
// Revision    : 1.0 - initial release
// ============================================================================
module midi_transmit
    import midi_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 31250,
    parameter int CYCLES_PER_BIT = CLK_FREQ / BAUD,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic [6:0] status,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    output logic       ready,
    output logic       dout,
    output logic       done
);

    logic       r_busy;
    logic [7:0] r_q0;
    logic [7:0] r_q1;
    logic [7:0] r_q2;
    logic [1:0] r_left;          // bytes still to hand to the serialiser
    logic [7:0] r_last_status;   // 8'h00 means "no running status"

    logic [7:0] w_status_byte;
    logic [1:0] w_data_len;
    logic       w_is_cv;
    logic       w_skip_status;
    logic       w_accept;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic       w_byte_done;
    logic       w_byte_take;

    assign w_status_byte = {1'b1, status};
    assign w_data_len    = midi_data_len(w_status_byte);
    assign w_is_cv       = is_channel_voice(w_status_byte);
    assign w_skip_status = (RUNNING_STATUS != 0) && w_is_cv && (w_status_byte == r_last_status);

    assign ready        = ~r_busy;
    assign w_accept     = din_valid & ~r_busy;
    assign w_byte_valid = r_busy & (r_left != 2'd0);
    assign w_byte_take  = w_byte_valid & w_byte_ready;
    // Only the stop bit of the last queued byte ends the message
    assign done         = r_busy & w_byte_done & (r_left == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_q0          <= 8'd0;
            r_q1          <= 8'd0;
            r_q2          <= 8'd0;
            r_left        <= 2'd0;
            r_last_status <= 8'd0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            if (w_skip_status) begin
                r_q0   <= {1'b0, data1};
                r_q1   <= {1'b0, data2};
                r_q2   <= 8'd0;
                r_left <= w_data_len;
            end else begin
                r_q0   <= w_status_byte;
                r_q1   <= {1'b0, data1};
                r_q2   <= {1'b0, data2};
                r_left <= w_data_len + 2'd1;
            end
            if (RUNNING_STATUS != 0) begin
                if (w_is_cv) begin
                    r_last_status <= w_status_byte;
                end else if (w_status_byte < 8'hF8) begin
                    // System common cancels running status; realtime does not
                    r_last_status <= 8'd0;
                end
            end
        end else begin
            if (w_byte_take) begin
                r_q0   <= r_q1;
                r_q1   <= r_q2;
                r_left <= r_left - 2'd1;
            end
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (w_byte_valid),
        .byte_data  (r_q0),
        .byte_ready (w_byte_ready),
        .byte_done  (w_byte_done),
        .dout       (dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_midi_transmit.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_transmit
// Description : Directed self-checking bench for midi_transmit. Two
//               instances (running status on / off) share fields; a UART
//               reference decoder per line collects transmitted bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_transmit;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid0 = 1'b0;
    logic       din_valid1 = 1'b0;
    logic [6:0] status = 7'd0;
    logic [6:0] data1  = 7'd0;
    logic [6:0] data2  = 7'd0;
    logic       ready0, dout0, done0;
    logic       ready1, dout1, done1;

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];

    always #5 clk = ~clk;

    midi_transmit #(
        .CLK_FREQ(100_000_000), .BAUD(31250), .CYCLES_PER_BIT(CPB), .RUNNING_STATUS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .din_valid(din_valid1), .status(status),
        .data1(data1), .data2(data2), .ready(ready1), .dout(dout1), .done(done1)
    );

    midi_transmit #(
        .CLK_FREQ(100_000_000), .BAUD(31250), .CYCLES_PER_BIT(CPB), .RUNNING_STATUS(0)
    ) dut0 (
        .clk(clk), .rst(rst), .din_valid(din_valid0), .status(status),
        .data1(data1), .data2(data2), .ready(ready0), .dout(dout0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s failed", tag);
        end
    endtask

    // Reference UART decoder: entered on the first low cycle of a start bit
    task automatic mon_frame(input bit use0);
        logic [7:0] b;
        logic       l;
        b = 8'd0;
        repeat (CPB / 2) @(negedge clk);
        l = use0 ? dout0 : dout1;
        if (!rst) chk("start_bit", {31'd0, l}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = use0 ? dout0 : dout1;
        end
        repeat (CPB) @(negedge clk);
        l = use0 ? dout0 : dout1;
        chk("stop_bit", {31'd0, l}, 32'd1);
        if (use0) rxq0.push_back(b);
        else      rxq1.push_back(b);
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst && dout1 === 1'b0) mon_frame(1'b0);
    end

    initial forever begin
        @(negedge clk);
        if (!rst && dout0 === 1'b0) mon_frame(1'b1);
    end

    always @(negedge clk) begin
        if (done0 === 1'b1) done_cnt0++;
        if (done1 === 1'b1) done_cnt1++;
    end

    // Offer one message, then time the fall of dout and the done pulse in
    // negedges after the accepting edge.
    task automatic send_msg(input bit use0, input logic [6:0] s, input logic [6:0] d1,
                            input logic [6:0] d2, output int fall_at, output int done_at);
        int n;
        n = 0;
        @(negedge clk);
        while (((use0 ? ready0 : ready1) !== 1'b1) && (n < 50 * CPB)) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, use0 ? ready0 : ready1}, 32'd1);
        status = s; data1 = d1; data2 = d2;
        if (use0) din_valid0 = 1'b1;
        else      din_valid1 = 1'b1;
        @(posedge clk);
        #1;
        din_valid0 = 1'b0;
        din_valid1 = 1'b0;
        status = 7'h7F; data1 = 7'h55; data2 = 7'h2A;
        chk("ready_drop", {31'd0, use0 ? ready0 : ready1}, 32'd0);
        fall_at = -1;
        done_at = -1;
        n = 0;
        while (done_at < 0 && n < 50 * CPB) begin
            @(negedge clk);
            n++;
            if (fall_at < 0 && (use0 ? dout0 : dout1) === 1'b0) fall_at = n;
            if ((use0 ? done0 : done1) === 1'b1) done_at = n;
        end
        @(negedge clk);
        chk("ready_after", {31'd0, use0 ? ready0 : ready1}, 32'd1);
    endtask

    // Expected bytes packed first-byte-most-significant in the low n bytes
    task automatic chk_bytes(input bit use0, input int n, input logic [63:0] expv);
        logic [7:0] got;
        chk("rx_count", use0 ? rxq0.size() : rxq1.size(), n);
        for (int i = 0; i < n; i++) begin
            got = 8'h00;
            if (use0 && rxq0.size() > i)  got = rxq0[i];
            if (!use0 && rxq1.size() > i) got = rxq1[i];
            chk($sformatf("rx_byte%0d", i), {24'd0, got}, {24'd0, expv[8*(n-1-i) +: 8]});
        end
        rxq0.delete();
        rxq1.delete();
    endtask

    initial begin
        int fa, da, base, n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ready1}, 32'd1);
        chk("reset_dout",  {31'd0, dout1},  32'd1);
        chk("reset_done",  {31'd0, done1},  32'd0);
        chk("reset_ready_rs0", {31'd0, ready0}, 32'd1);
        #1 rst = 1'b0;

        // Note-on, full message
        send_msg(1'b0, 7'h10, 7'h3C, 7'h64, fa, da);
        chk("noteon_fall", fa, 2);
        chk("noteon_done", da, 30 * CPB + 1);
        chk_bytes(1'b0, 3, 64'h903C64);
        chk("noteon_done_cnt", done_cnt1, 1);

        // Same note-on: status compressed away
        send_msg(1'b0, 7'h10, 7'h3C, 7'h64, fa, da);
        chk("rs_fall", fa, 2);
        chk("rs_done", da, 20 * CPB + 1);
        chk_bytes(1'b0, 2, 64'h3C64);
        chk("rs_done_cnt", done_cnt1, 2);

        // Running status disabled: status always sent
        send_msg(1'b1, 7'h10, 7'h3C, 7'h64, fa, da);
        chk("nors_done_a", da, 30 * CPB + 1);
        send_msg(1'b1, 7'h10, 7'h3C, 7'h64, fa, da);
        chk("nors_done_b", da, 30 * CPB + 1);
        chk_bytes(1'b1, 6, 64'h903C64903C64);
        chk("nors_done_cnt", done_cnt0, 2);

        // Program change, realtime clock, program change again
        send_msg(1'b0, 7'h45, 7'h07, 7'h00, fa, da);
        chk("pc_done", da, 20 * CPB + 1);
        send_msg(1'b0, 7'h78, 7'h00, 7'h00, fa, da);
        chk("rt_done", da, 10 * CPB + 1);
        send_msg(1'b0, 7'h45, 7'h07, 7'h00, fa, da);
        chk("pc_rs_done", da, 10 * CPB + 1);
        chk_bytes(1'b0, 4, 64'hC507F807);

        // Sysex end between two note-ons cancels running status
        send_msg(1'b0, 7'h10, 7'h3C, 7'h64, fa, da);
        send_msg(1'b0, 7'h77, 7'h00, 7'h00, fa, da);
        chk("f7_done", da, 10 * CPB + 1);
        send_msg(1'b0, 7'h10, 7'h3C, 7'h64, fa, da);
        chk("after_f7_done", da, 30 * CPB + 1);
        chk_bytes(1'b0, 7, 64'h903C64F7903C64);

        // din_valid held high across three messages
        base = done_cnt1;
        @(negedge clk);
        status = 7'h10; data1 = 7'h01; data2 = 7'h02;
        din_valid1 = 1'b1;
        for (int m = 0; m < 3; m++) begin
            n = 0;
            while (ready1 !== 1'b1 && n < 50 * CPB) begin
                @(negedge clk);
                n++;
            end
            chk("held_ready", {31'd0, ready1}, 32'd1);
            @(posedge clk);
            #1;
            chk("held_taken", {31'd0, ready1}, 32'd0);
            case (m)
                0: begin status = 7'h20; data1 = 7'h03; data2 = 7'h04; end
                1: begin status = 7'h50; data1 = 7'h05; data2 = 7'h11; end
                default: din_valid1 = 1'b0;
            endcase
            @(negedge clk);
        end
        n = 0;
        while (ready1 !== 1'b1 && n < 50 * CPB) begin
            @(negedge clk);
            n++;
        end
        chk("held_done_cnt", done_cnt1 - base, 3);
        chk_bytes(1'b0, 7, 64'h0102A00304D005);

        // Reset in the middle of a frame
        @(negedge clk);
        status = 7'h10; data1 = 7'h3C; data2 = 7'h64;
        din_valid1 = 1'b1;
        @(posedge clk);
        #1 din_valid1 = 1'b0;
        base = done_cnt1;
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_dout", {31'd0, dout1}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_dout",  {31'd0, dout1},  32'd1);
        chk("rst_ready", {31'd0, ready1}, 32'd1);
        chk("rst_done",  {31'd0, done1},  32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        chk("rst_no_done", done_cnt1, base);
        rxq0.delete();
        rxq1.delete();
        send_msg(1'b0, 7'h45, 7'h07, 7'h00, fa, da);
        chk("post_rst_fall", fa, 2);
        chk("post_rst_done", da, 20 * CPB + 1);
        chk_bytes(1'b0, 2, 64'hC507);
        chk("post_rst_done_cnt", done_cnt1, base + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
